// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator slice.
// Saturating accumulation is selected with the PRODUCT_ACC_SATURATE_EN macro.
package product_acc_pkg;

  localparam int PRODUCT_W       = 8;
  localparam int COUNT_W         = 8;
  localparam int DEFAULT_ACC_W   = 16;
  localparam int DEFAULT_MAX_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_adder.sv
// Combinational accumulator + product adder with carry out.
// PRODUCT_ACC_SATURATE_EN clamps the sum to all-ones on carry; otherwise it wraps.
module acc_adder
  import product_acc_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic [ACC_W-1:0]     acc,
  input  logic [PRODUCT_W-1:0] product,
  output logic [ACC_W-1:0]     sum,
  output logic                 carry
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide  = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, product};
    carry = wide[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
    // Once clamped, any further non-zero product carries again, so the clamp sticks.
    sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for the 8-bit approximate-multiplier product stream.
// Overflow handling (wrap vs clamp) is selected by PRODUCT_ACC_SATURATE_EN in acc_adder.
//
// Handshakes: a beat moves on the rising edge where in_valid & in_ready are both
// high; a result moves on the rising edge where out_valid & out_ready are both high.
// out_valid and the result fields stay constant until the result moves.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W   = DEFAULT_ACC_W,
  parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRODUCT_W-1:0] in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [COUNT_W-1:0]   out_count,
  output logic                 out_ovf,
  output state_t               fsm_state
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [COUNT_W-1:0] cnt;
  logic               ovf;

  logic               in_beat;
  logic               out_xfer;
  logic [ACC_W-1:0]   add_base;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic [COUNT_W-1:0] cnt_next;
  logic               ovf_next;
  logic               closing;

  assign in_ready  = (state != HOLD) && !rst;
  assign in_beat   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign fsm_state = state;

  // A new frame starts from zero, so the single adder serves both IDLE and ACCUM.
  assign add_base = (state == IDLE) ? '0 : acc;
  assign cnt_next = (state == IDLE) ? COUNT_W'(1) : cnt + COUNT_W'(1);
  assign ovf_next = ((state == IDLE) ? 1'b0 : ovf) | add_carry;
  assign closing  = in_last || (cnt_next == COUNT_W'(MAX_LEN));

  acc_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .acc    (add_base),
    .product(in_product),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_beat) begin
            acc <= add_sum;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (closing) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= add_sum;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench: a 16-bit and an 8-bit accumulator share one input stream; a frame-level
// arithmetic model predicts every result for both widths.
module tb_product_accumulator;
  import product_acc_pkg::*;

  localparam int MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_product = 8'h00;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  state_t      fsm_state;

  logic        in_ready8, out_valid8, out_ovf8;
  logic [7:0]  out_sum8;
  logic [7:0]  out_count8;
  state_t      fsm_state8;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] exp_sum16_q[$];
  logic [7:0]  exp_sum8_q[$];
  logic [7:0]  exp_cnt_q[$];
  logic        exp_ovf8_q[$];
  int          frame_total = 0;
  int          frame_beats = 0;
  bit          rand_active = 1'b0;

  product_accumulator #(.ACC_W(16), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf), .fsm_state(fsm_state)
  );

  product_accumulator #(.ACC_W(8), .MAX_LEN(MAX_LEN)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid8),
    .out_ready(out_ready), .out_sum(out_sum8), .out_count(out_count8),
    .out_ovf(out_ovf8), .fsm_state(fsm_state8)
  );

  always #5 clk = ~clk;

  // 8-bit frame result from the true (unbounded) frame total.
  function automatic logic [7:0] ref_sum8(input int total);
`ifdef PRODUCT_ACC_SATURATE_EN
    return (total > 255) ? 8'hFF : 8'(total);
`else
    return 8'(total % 256);
`endif
  endfunction

  // Scoreboard: frame model on accepted beats, comparison on accepted results.
  always @(negedge clk) begin
    if (rst) begin
      frame_total = 0;
      frame_beats = 0;
      exp_sum16_q.delete();
      exp_sum8_q.delete();
      exp_cnt_q.delete();
      exp_ovf8_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        compared++;
        if (exp_sum16_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_result: got sum=%h count=%0d, required no result", out_sum, out_count);
        end else begin
          logic [15:0] e16;
          logic [7:0]  e8, ec;
          logic        eo;
          e16 = exp_sum16_q.pop_front();
          e8  = exp_sum8_q.pop_front();
          ec  = exp_cnt_q.pop_front();
          eo  = exp_ovf8_q.pop_front();
          if (out_sum !== e16 || out_count !== ec || out_ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL result16: got sum=%h count=%0d ovf=%b, required sum=%h count=%0d ovf=0",
                     out_sum, out_count, out_ovf, e16, ec);
          end
          compared++;
          if (out_valid8 !== 1'b1 || out_sum8 !== e8 || out_count8 !== ec || out_ovf8 !== eo) begin
            mismatched++;
            $display("FAIL result8: got valid=%b sum=%h count=%0d ovf=%b, required valid=1 sum=%h count=%0d ovf=%b",
                     out_valid8, out_sum8, out_count8, out_ovf8, e8, ec, eo);
          end
        end
      end
      if (in_valid && in_ready) begin
        compared++;
        if (in_ready8 !== 1'b1) begin
          mismatched++;
          $display("FAIL ready8_match: got in_ready8=%b, required 1", in_ready8);
        end
        frame_total += int'(in_product);
        frame_beats++;
        if (in_last || frame_beats == MAX_LEN) begin
          exp_sum16_q.push_back(16'(frame_total));
          exp_sum8_q.push_back(ref_sum8(frame_total));
          exp_cnt_q.push_back(8'(frame_beats));
          exp_ovf8_q.push_back(frame_total > 255);
          frame_total = 0;
          frame_beats = 0;
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] p, input logic l);
    int guard;
    guard = 0;
    in_valid   = 1'b1;
    in_product = p;
    in_last    = l;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL beat_timeout: got in_ready=0 for 200 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_count !== 8'h0 || out_ovf !== 1'b0 ||
        in_ready !== 1'b0 || fsm_state !== IDLE) begin
      mismatched++;
      $display("FAIL reset_values: got valid=%b sum=%h count=%0d ovf=%b ready=%b state=%0d, required 0/0/0/0/0/IDLE",
               out_valid, out_sum, out_count, out_ovf, in_ready, fsm_state);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_frame();
    out_ready = 1'b1;
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    send_beat(8'h30, 1'b1);
    compared++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0060 || out_count !== 8'd3 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_frame: got valid=%b sum=%h count=%0d ovf=%b ready=%b, required 1/0060/3/0/0",
               out_valid, out_sum, out_count, out_ovf, in_ready);
    end
    @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_ready_return: got ready=%b valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    send_beat(8'hE1, 1'b1);
    compared++;
    if (out_valid !== 1'b1 || out_sum !== 16'h00E1 || out_count !== 8'd1) begin
      mismatched++;
      $display("FAIL single_beat: got valid=%b sum=%h count=%0d, required 1/00e1/1", out_valid, out_sum, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_forced_close();
    out_ready = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) send_beat(8'h01, 1'b0);
    compared++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0010 || out_count !== 8'd16 || out_sum8 !== 8'h10) begin
      mismatched++;
      $display("FAIL forced_close: got valid=%b sum=%h count=%0d sum8=%h, required 1/0010/16/10",
               out_valid, out_sum, out_count, out_sum8);
    end
    send_beat(8'h01, 1'b1);
    compared++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0001 || out_count !== 8'd1) begin
      mismatched++;
      $display("FAIL forced_close_next: got valid=%b sum=%h count=%0d, required 1/0001/1", out_valid, out_sum, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    logic [7:0] exp8;
`ifdef PRODUCT_ACC_SATURATE_EN
    exp8 = 8'hFF;
`else
    exp8 = 8'h10;
`endif
    out_ready = 1'b1;
    send_beat(8'hF0, 1'b0);
    send_beat(8'h20, 1'b1);
    compared++;
    if (out_valid8 !== 1'b1 || out_sum8 !== exp8 || out_ovf8 !== 1'b1 || out_count8 !== 8'd2) begin
      mismatched++;
      $display("FAIL overflow8: got valid=%b sum=%h ovf=%b count=%0d, required 1/%h/1/2",
               out_valid8, out_sum8, out_ovf8, out_count8, exp8);
    end
    compared++;
    if (out_sum !== 16'h0110 || out_ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow16: got sum=%h ovf=%b, required 0110/0", out_sum, out_ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] p [3];
    int total;
    total = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p[i] = 8'($urandom_range(0, 255));
      total += int'(p[i]);
    end
    for (int i = 0; i < 3; i++) send_beat(p[i], i == 2);
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (out_valid !== 1'b1 || out_sum !== 16'(total) || in_ready !== 1'b0 || out_count !== 8'd3) begin
        mismatched++;
        $display("FAIL backpressure_hold: cycle %0d got valid=%b sum=%h ready=%b count=%0d, required 1/%h/0/3",
                 c, out_valid, out_sum, in_ready, out_count, 16'(total));
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_release: got ready=%b valid=%b, required 1/0", in_ready, out_valid);
    end
    send_beat(8'h07, 1'b1);
    compared++;
    if (out_sum !== 16'h0007 || out_count !== 8'd1) begin
      mismatched++;
      $display("FAIL backpressure_next: got sum=%h count=%0d, required 0007/1", out_sum, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    send_beat(8'h40, 1'b0);
    send_beat(8'h40, 1'b0);
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_count !== 8'h0 || out_ovf !== 1'b0 ||
        in_ready !== 1'b0 || fsm_state !== IDLE || out_count8 !== 8'h0) begin
      mismatched++;
      $display("FAIL async_reset: got valid=%b sum=%h count=%0d ovf=%b ready=%b state=%0d, required 0/0/0/0/0/IDLE",
               out_valid, out_sum, out_count, out_ovf, in_ready, fsm_state);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(8'h05, 1'b1);
    compared++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0005 || out_count !== 8'd1) begin
      mismatched++;
      $display("FAIL after_reset_frame: got valid=%b sum=%h count=%0d, required 1/0005/1", out_valid, out_sum, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    rand_active = 1'b1;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          int len;
          len = $urandom_range(1, 20);
          for (int i = 0; i < len; i++) begin
            int bubbles;
            bubbles = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
            repeat (bubbles) begin
              @(posedge clk);
              #1;
            end
            send_beat(8'($urandom_range(0, 255)), (i == len - 1) && ($urandom_range(0, 3) != 0));
          end
        end
        rand_active = 1'b0;
      end
      begin
        while (rand_active) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while ((exp_sum16_q.size() != 0 || out_valid) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    compared++;
    if (exp_sum16_q.size() != 0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL drain: got %0d results pending valid=%b, required 0 pending", exp_sum16_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_forced_close();
    test_overflow();
    test_backpressure();
    test_mid_reset();
    test_random();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
